mem_access_unit: RTL and testbench

- Parametrised load/store access unit between the processor's memory-address/data registers and the external memory port.
- Replaces direct strobing of oMemRead/oMemWrite with:
  - a request/response handshake;
  - byte/half/word (and dword) sizing, byte enables, lane steering and sign extension on loads;
  - a bus timeout.
- The processor control unit issues one request and stalls until the single-cycle response pulse.

---
 rtl/mau_pkg.sv | 34 +++
 rtl/mau_lane_steer.sv | 46 ++++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared size encodings, FSM state type and byte-enable helpers for mem_access_unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_t;

  // Low offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] mau_size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] mau_be(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_BYTE: return 8'h01 << off;
      SZ_HALF: return 8'h03 << off;
      SZ_WORD: return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_steer.sv
// Combinational lane steering: store data replication across lanes and
// load data shift / zero- or sign-extension.
module mau_lane_steer
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_rep,
  input  logic [1:0]        ld_size,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_res
);

  // Each lane takes the source byte matching its position within the access size.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign st_rep[8*gi +: 8] = (st_size == SZ_BYTE) ? st_data[7:0] :
                               (st_size == SZ_HALF) ? st_data[8*(gi%2) +: 8] :
                               (st_size == SZ_WORD) ? st_data[8*(gi%4) +: 8] :
                                                      st_data[8*gi +: 8];
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              sign_bit;

  always_comb begin
    shifted   = ld_raw >> {ld_off, 3'b000};
    keep_mask = '1;
    sign_bit  = shifted[DATA_W-1];
    case (ld_size)
      SZ_BYTE: begin keep_mask = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
      SZ_HALF: begin keep_mask = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
      SZ_WORD: begin keep_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin end
    endcase
    // A full-width access has an all-ones mask, so the sign fill drops out.
    ld_res = (shifted & keep_mask) | ({DATA_W{ld_signed & sign_bit}} & ~keep_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: request/response handshake, sizing, lane steering and bus timeout.
// Optional macro MAU_ALIGN_CHECK_EN rejects misaligned requests instead of aligning them down.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iReqValid,
  output logic                oReqReady,
  input  logic                iReqWrite,
  input  logic [1:0]          iReqSize,
  input  logic                iReqSigned,
  input  logic [ADDR_W-1:0]   iReqAddr,
  input  logic [DATA_W-1:0]   iReqData,
  output logic                oRspValid,
  output logic [DATA_W-1:0]   oRspData,
  output logic                oRspErr,
  output logic [ADDR_W-1:0]   oMemAddr,
  output logic [DATA_W-1:0]   oMemData,
  output logic [DATA_W/8-1:0] oMemBe,
  output logic                oMemRead,
  output logic                oMemWrite,
  input  logic [DATA_W-1:0]   iMemData,
  input  logic                iMemRdy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  mau_state_t        state_reg, state_next;
  logic              write_reg, signed_reg, err_reg;
  logic [1:0]        size_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [BE_W-1:0]   be_reg;
  logic [DATA_W-1:0] wdata_reg, rdata_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [2:0]        req_off3, req_mask;
  logic [OFF_W-1:0]  aligned_off;
  logic              req_illegal, size_bad, timeout_hit;
  logic [DATA_W-1:0] store_rep, load_res;

  assign req_off3    = 3'(iReqAddr[OFF_W-1:0]);
  assign req_mask    = mau_size_mask(iReqSize);
  assign aligned_off = OFF_W'(req_off3 & ~req_mask);
  assign size_bad    = (iReqSize == SZ_DWORD) && (DATA_W < 64);
`ifdef MAU_ALIGN_CHECK_EN
  assign req_illegal = size_bad || (|(req_off3 & req_mask));
`else
  assign req_illegal = size_bad;
`endif
  assign timeout_hit = (TIMEOUT != 0) && !iMemRdy && (cnt_reg == CNT_LAST);

  mau_lane_steer #(.DATA_W(DATA_W)) u_lane_steer (
    .st_size   (iReqSize),
    .st_data   (iReqData),
    .st_rep    (store_rep),
    .ld_size   (size_reg),
    .ld_off    (off_reg),
    .ld_signed (signed_reg),
    .ld_raw    (iMemData),
    .ld_res    (load_res)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (iReqValid) state_next = req_illegal ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (iMemRdy || timeout_hit) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      write_reg  <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      size_reg   <= '0;
      off_reg    <= '0;
      addr_reg   <= '0;
      be_reg     <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (iReqValid) begin
          write_reg  <= iReqWrite;
          signed_reg <= iReqSigned;
          size_reg   <= iReqSize;
          off_reg    <= aligned_off;
          addr_reg   <= {iReqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_reg     <= BE_W'(mau_be(iReqSize, 3'(aligned_off)));
          wdata_reg  <= store_rep;
          rdata_reg  <= '0;
          err_reg    <= req_illegal;
          cnt_reg    <= '0;
        end
        ST_ACCESS: begin
          if (iMemRdy) begin
            rdata_reg <= write_reg ? '0 : load_res;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: begin end
      endcase
    end
  end

  always_comb begin
    oReqReady = (state_reg == ST_IDLE);
    oMemRead  = (state_reg == ST_ACCESS) && !write_reg;
    oMemWrite = (state_reg == ST_ACCESS) && write_reg;
    oMemAddr  = addr_reg;
    oMemData  = wdata_reg;
    oMemBe    = be_reg;
    oRspValid = (state_reg == ST_RESP);
    oRspErr   = oRspValid && err_reg;
    oRspData  = oRspValid ? rdata_reg : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_W=32, TIMEOUT=4): directed requests push
// expected responses; a negedge monitor pops and compares on every response pulse.
module tb_mem_access_unit;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iReqWrite = 1'b0;
  logic [1:0]  iReqSize = 2'd0;
  logic        iReqSigned = 1'b0;
  logic [31:0] iReqAddr = '0;
  logic [31:0] iReqData = '0;
  logic        oRspValid;
  logic [31:0] oRspData;
  logic        oRspErr;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [3:0]  oMemBe;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] iMemData = '0;
  logic        iMemRdy = 1'b0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqWrite(iReqWrite), .iReqSize(iReqSize), .iReqSigned(iReqSigned),
    .iReqAddr(iReqAddr), .iReqData(iReqData), .oRspValid(oRspValid),
    .oRspData(oRspData), .oRspErr(oRspErr), .oMemAddr(oMemAddr),
    .oMemData(oMemData), .oMemBe(oMemBe), .oMemRead(oMemRead),
    .oMemWrite(oMemWrite), .iMemData(iMemData), .iMemRdy(iMemRdy)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge iClk) begin
    if (oRspValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got data 0x%08h err %0b with no request outstanding",
                 oRspData, oRspErr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", oRspData, e.data);
        chk("rsp_err", {31'd0, oRspErr}, {31'd0, e.err});
      end
    end
  end

  // Issue one request; rdy_at is the ACCESS cycle index where iMemRdy is raised (-1 = never).
  task automatic run_req(input string nm, input logic w, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input int rdy_at, input logic [31:0] rd,
                         input logic [3:0] ebe, input logic [31:0] emaddr,
                         input logic [31:0] emdata, input int estrobes,
                         input logic [31:0] edata, input logic eerr);
    int nstrobe;
    bit seen;
    exp_t e;
    e.data = edata;
    e.err  = eerr;
    exp_q.push_back(e);
    @(negedge iClk);
    iReqValid = 1'b1; iReqWrite = w; iReqSize = sz; iReqSigned = sgn;
    iReqAddr = addr; iReqData = wd;
    @(posedge iClk);
    #1 iReqValid = 1'b0;
    nstrobe = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge iClk);
      if (oRspValid === 1'b1) begin
        seen = 1;
      end else if (oMemRead === 1'b1 || oMemWrite === 1'b1) begin
        if (nstrobe == 0) begin
          chk({nm, "_be"}, {28'd0, oMemBe}, {28'd0, ebe});
          chk({nm, "_maddr"}, oMemAddr, emaddr);
          chk({nm, "_dir"}, {30'd0, oMemWrite, oMemRead}, {30'd0, w, ~w});
          if (w) chk({nm, "_mdata"}, oMemData, emdata);
        end
        iMemRdy  = (nstrobe == rdy_at);
        iMemData = rd;
        nstrobe++;
      end
    end
    iMemRdy = 1'b0;
    chk({nm, "_rsp_seen"}, {31'd0, seen}, 32'd1);
    chk({nm, "_strobes"}, nstrobe, estrobes);
    $display("txn %s: addr=0x%08h size=%0d write=%0b strobes=%0d", nm, addr, sz, w, nstrobe);
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("rst_req_ready", {31'd0, oReqReady}, 32'd1);
    chk("rst_rsp_valid", {31'd0, oRspValid}, 32'd0);
    chk("rst_strobes", {30'd0, oMemRead, oMemWrite}, 32'd0);
    chk("rst_mem_be", {28'd0, oMemBe}, 32'd0);
    chk("rst_mem_addr", oMemAddr, 32'd0);
    chk("rst_rsp_data", oRspData, 32'd0);
    iRst = 1'b0;

    run_req("ld_word",   0, 2'd2, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF,
            4'hF, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    run_req("ld_sbyte",  0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h80123456,
            4'h8, 32'h100, 32'h0, 1, 32'hFFFFFF80, 0);
    run_req("ld_ubyte",  0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h80123456,
            4'h8, 32'h100, 32'h0, 2, 32'h00000080, 0);
    run_req("st_half",   1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0, 32'h0,
            4'hC, 32'h200, 32'hABCDABCD, 1, 32'h0, 0);
    run_req("ld_timeout",0, 2'd2, 0, 32'h300, 32'h0, -1, 32'h11111111,
            4'hF, 32'h300, 32'h0, 4, 32'h0, 1);
    run_req("ld_rdy_last",0, 2'd2, 0, 32'h304, 32'h0, 3, 32'h12345678,
            4'hF, 32'h304, 32'h0, 4, 32'h12345678, 0);
    run_req("ld_shalf",  0, 2'd1, 1, 32'h106, 32'h0, 0, 32'h80017FFF,
            4'hC, 32'h104, 32'h0, 1, 32'hFFFF8001, 0);
    run_req("st_byte",   1, 2'd0, 0, 32'h001, 32'h0000005A, 0, 32'h0,
            4'h2, 32'h000, 32'h5A5A5A5A, 1, 32'h0, 0);
`ifdef MAU_ALIGN_CHECK_EN
    run_req("ld_misalign",0, 2'd2, 0, 32'h101, 32'h0, 0, 32'hCAFEF00D,
            4'hF, 32'h100, 32'h0, 0, 32'h0, 1);
`else
    run_req("ld_misalign",0, 2'd2, 0, 32'h101, 32'h0, 0, 32'hCAFEF00D,
            4'hF, 32'h100, 32'h0, 1, 32'hCAFEF00D, 0);
`endif
    run_req("ld_dword",  0, 2'd3, 0, 32'h108, 32'h0, 0, 32'h55555555,
            4'hF, 32'h108, 32'h0, 0, 32'h0, 1);

    // Reset while a read is pending: strobe drops, ready returns, no response follows.
    @(negedge iClk);
    iReqValid = 1'b1; iReqWrite = 1'b0; iReqSize = 2'd2; iReqAddr = 32'h400;
    @(posedge iClk);
    #1 iReqValid = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    chk("rst_mid_pre_read", {31'd0, oMemRead}, 32'd1);
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst_mid_read", {31'd0, oMemRead}, 32'd0);
    chk("rst_mid_ready", {31'd0, oReqReady}, 32'd1);
    iRst = 1'b0;
    repeat (10) @(negedge iClk);
    $display("txn rst_mid: addr=0x00000400 abandoned");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
